// File: rtl/shadow_tracer_pkg.sv
// Shared types and constants for the shadow tracer controller:
// FSM state enum, snapshot bundle, trigger-report framing and command bytes.
package shadow_tracer_pkg;

    typedef enum logic [2:0] {
        ST_WAIT_RST,
        ST_SETTLE,
        ST_ARMED,
        ST_DUMP,
        ST_HALT
    } state_e;

    localparam int         DUMP_LEN       = 12;
    localparam logic [7:0] DUMP_SYNC_HEAD = 8'hA5;
    localparam logic [7:0] DUMP_SYNC_TAIL = 8'h5A;
    localparam logic [7:0] CMD_REARM      = 8'h52;

    // Bit positions inside the 8-bit active-low control vectors.
    typedef enum int unsigned {
        CTRL_BUSAK = 0,
        CTRL_HALT  = 1,
        CTRL_RFSH  = 2,
        CTRL_WR    = 3,
        CTRL_RD    = 4,
        CTRL_IORQ  = 5,
        CTRL_MREQ  = 6,
        CTRL_M1    = 7
    } ctrl_bit_e;

    // Bus state captured on the trigger cycle.
    // flags = {addr_match, data_match, ctrl_match}
    typedef struct packed {
        logic [31:0] count;
        logic [15:0] addr;
        logic [7:0]  data;
        logic [7:0]  real_ctrl;
        logic [7:0]  shadow_ctrl;
        logic [2:0]  flags;
    } snap_t;

    // Report byte at position idx of the trigger frame.
    function automatic logic [7:0] dump_byte(
        input snap_t      s,
        input logic [3:0] idx
    );
        logic [7:0] b;
        case (idx)
            4'd0:    b = DUMP_SYNC_HEAD;
            4'd1:    b = s.count[31:24];
            4'd2:    b = s.count[23:16];
            4'd3:    b = s.count[15:8];
            4'd4:    b = s.count[7:0];
            4'd5:    b = s.addr[15:8];
            4'd6:    b = s.addr[7:0];
            4'd7:    b = s.data;
            4'd8:    b = s.real_ctrl;
            4'd9:    b = s.shadow_ctrl;
            4'd10:   b = {5'b0, s.flags};
            4'd11:   b = DUMP_SYNC_TAIL;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/shadow_trace_ctrl_ser.sv
// shadow_dump_ser: serialises the latched snapshot as a 12-byte report.
// Ports: clk/rst, start strobe, snapshot in, tx valid/ready/data, done strobe.
module shadow_dump_ser
    import shadow_tracer_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  snap_t      snap,
    input  logic       tx_ready,
    output logic [7:0] tx_data,
    output logic       tx_valid,
    output logic       done
);

    logic       valid_q, valid_d;
    logic [3:0] idx_q, idx_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            idx_q   <= 4'd0;
        end else begin
            valid_q <= valid_d;
            idx_q   <= idx_d;
        end
    end

    // Next byte is presented on the accepting edge, no bubble.
    always_comb begin
        valid_d = valid_q;
        idx_d   = idx_q;
        done    = 1'b0;
        if (start) begin
            valid_d = 1'b1;
            idx_d   = 4'd0;
        end else if (valid_q && tx_ready) begin
            if (idx_q == 4'(DUMP_LEN - 1)) begin
                valid_d = 1'b0;
                done    = 1'b1;
            end else begin
                idx_d = idx_q + 4'd1;
            end
        end
    end

    assign tx_valid = valid_q;
    assign tx_data  = valid_q ? dump_byte(snap, idx_q) : 8'h00;

endmodule

// File: rtl/shadow_trace_ctrl.sv
// shadow_trace_ctrl: releases the shadow core, arms after a settle window,
// counts bus cycles, snapshots the first filtered mismatch and reports it.
// Ports: CLK_n/RESET, target_reset_n, compare flags, A/D/ctrl buses,
// shadow_reset_n, armed, triggered, tx_* to UART, rx_* from UART.
// Macro SHADOW_TRACE_FULL_MATCH_EN: trigger on ctrl, data and addr compare.
module shadow_trace_ctrl
    import shadow_tracer_pkg::*;
#(
    parameter int SETTLE_CYCLES   = 16,
    parameter int MISMATCH_FILTER = 1
) (
    input  logic        CLK_n,
    input  logic        RESET,
    input  logic        target_reset_n,
    input  logic        ctrl_match,
    input  logic        data_match,
    input  logic        addr_match,
    input  logic [15:0] A,
    input  logic [7:0]  D,
    input  logic [7:0]  real_ctrl,
    input  logic [7:0]  shadow_ctrl,
    output logic        shadow_reset_n,
    output logic        armed,
    output logic        triggered,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid
);

    localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES);
    localparam logic [4:0]  FILT_N      = 5'(MISMATCH_FILTER);

    state_e      state_q, state_d;
    logic [15:0] settle_q, settle_d;
    logic [31:0] cycle_q, cycle_d;
    logic [3:0]  filt_q, filt_d;
    snap_t       snap_q, snap_d;
    logic        armed_q, armed_d;
    logic        trig_q, trig_d;
    logic        srst_q;
    logic        mismatch, fire, rearm, ser_done;

`ifdef SHADOW_TRACE_FULL_MATCH_EN
    assign mismatch = ~(ctrl_match & data_match & addr_match);
`else
    assign mismatch = ~ctrl_match;
`endif

    // Target reset in the same cycle suppresses a trigger.
    assign fire = (state_q == ST_ARMED) && target_reset_n && mismatch
               && (({1'b0, filt_q} + 5'd1) == FILT_N);
    assign rearm = (state_q == ST_HALT) && rx_valid
                && (rx_data == CMD_REARM);

    always_ff @(posedge CLK_n) begin
        if (RESET) begin
            state_q  <= ST_WAIT_RST;
            settle_q <= 16'd0;
            cycle_q  <= 32'd0;
            filt_q   <= 4'd0;
            snap_q   <= '0;
            armed_q  <= 1'b0;
            trig_q   <= 1'b0;
            srst_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            cycle_q  <= cycle_d;
            filt_q   <= filt_d;
            snap_q   <= snap_d;
            armed_q  <= armed_d;
            trig_q   <= trig_d;
            srst_q   <= target_reset_n;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_WAIT_RST:
                if (target_reset_n) state_d = ST_SETTLE;
            ST_SETTLE:
                if (!target_reset_n)       state_d = ST_WAIT_RST;
                else if (settle_q == 16'd0) state_d = ST_ARMED;
            ST_ARMED:
                if (!target_reset_n) state_d = ST_WAIT_RST;
                else if (fire)       state_d = ST_DUMP;
            ST_DUMP:
                if (ser_done) state_d = ST_HALT;
            ST_HALT:
                if (!target_reset_n) state_d = ST_WAIT_RST;
                else if (rearm)      state_d = ST_SETTLE;
            default: state_d = ST_WAIT_RST;
        endcase
    end

    always_comb begin
        settle_d = settle_q;
        cycle_d  = cycle_q;
        filt_d   = filt_q;
        snap_d   = snap_q;
        trig_d   = trig_q;
        armed_d  = (state_d == ST_ARMED);
        unique case (state_q)
            ST_WAIT_RST: settle_d = SETTLE_LOAD;
            ST_SETTLE: begin
                if (settle_q != 16'd0) settle_d = settle_q - 16'd1;
                cycle_d = 32'd0;
                filt_d  = 4'd0;
            end
            ST_ARMED: begin
                cycle_d = cycle_q + 32'(cycle_q != '1);
                filt_d  = mismatch ? filt_q + 4'd1 : 4'd0;
                if (fire) begin
                    snap_d.count       = cycle_q;
                    snap_d.addr        = A;
                    snap_d.data        = D;
                    snap_d.real_ctrl   = real_ctrl;
                    snap_d.shadow_ctrl = shadow_ctrl;
                    snap_d.flags = {addr_match, data_match, ctrl_match};
                    trig_d = 1'b1;
                end
            end
            ST_HALT: if (rearm) settle_d = SETTLE_LOAD;
            default: ;
        endcase
        if (state_d == ST_WAIT_RST || state_d == ST_SETTLE)
            trig_d = 1'b0;
    end

    shadow_dump_ser u_ser (
        .clk      (CLK_n),
        .rst      (RESET),
        .start    (fire),
        .snap     (snap_q),
        .tx_ready (tx_ready),
        .tx_data  (tx_data),
        .tx_valid (tx_valid),
        .done     (ser_done)
    );

    assign shadow_reset_n = srst_q;
    assign armed          = armed_q;
    assign triggered      = trig_q;

endmodule
